ars_shift_sequencer: RTL and testbench
======================================

Name: ars_shift_sequencer

Overview:
- Multi-cycle controller that performs arithmetic right shifts of any amount using one shared ArithmeticRightShifter instance.
- The shifter instance is N-bit data with a 2-bit control, so it shifts by 0..3 places per pass.
- The sequencer accepts a request over a valid/ready handshake and feeds the registered operand back through the shifter in steps of at most 3.
- It presents the sign-extended result over a valid/ready output handshake. It sits between the ALU issue logic and the shifter datapath.

Parameters:
- N, 5, data width; passed to the ArithmeticRightShifter instance.
- AMT_W, 4, width of the requested shift amount.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  sequencer can accept a request.
- in_data  input  N  two's-complement operand.
- in_amt  input  AMT_W  unsigned shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  N  shifted result.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; data register and remaining counter clear to 0.
  - out_valid=0, out_data=0, busy=0, in_ready=1 while rst_n is low.
  - Reset asserted mid-operation discards the operation; no out_valid is produced for it.
- States and outputs:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, busy=1.
  - DONE: in_ready=0, out_valid=1, busy=1.
  - All outputs are decoded from registered state and registers; there is no combinational path from any input to any output.
- Accept: in_valid && in_ready at an edge does all of the following.
  - Load the data register with in_data.
  - Load remaining with eff = min(in_amt, N-1). Amounts of N-1 or more all produce a result of all sign bits.
  - Next state is SHIFT if eff>0, else DONE.
- SHIFT, each cycle:
  - step = min(remaining, 3) drives the shifter control.
  - Data register is loaded with the shifter output; remaining -= step.
  - If remaining-step == 0, next state is DONE; otherwise stay in SHIFT.
- DONE:
  - out_data equals the data register and is held stable while out_ready=0.
  - out_valid && out_ready at an edge moves the state to IDLE.
  - A new request can only be accepted in IDLE, so there is no accept in the same cycle as retirement.
- Latency and throughput:
  - out_valid rises 1 + ceil(eff/3) edges after the accept edge; for eff=0 it rises 1 edge after.
  - Minimum occupancy is 2 cycles per operation when out_ready is held high.
- Arithmetic:
  - Result equals floor(in_data_signed / 2^eff), i.e. the sign bit is replicated.
  - No width growth: the remaining counter is ceil(log2(N)) bits wide and never underflows.
- in_data and in_amt are ignored outside an accept edge.

Optional Feature:
- Macro: ARS_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit, after out_ready).
  - abort=1 at an edge in SHIFT or DONE sends the state to IDLE. The data register and remaining clear to 0, and the result is not delivered.
  - abort in IDLE is ignored. abort has priority over DONE retirement.
- Undefined: no abort port; an operation always runs to DONE.

Test Plan:
- Accept in_data=01010, in_amt=2 with out_ready=1 -> out_valid high exactly 2 edges after accept, out_data=00010; in_ready low during those cycles.
- in_data=10110, in_amt=3 -> one SHIFT cycle, out_data=11110 (-2); 10110 with in_amt=1 -> out_data=11011 (-5).
- in_data=10110, in_amt=9 -> clamped to 4, two SHIFT cycles (step 3 then 1), out_data=11111; in_data=01010, in_amt=15 -> out_data=00000.
- in_data=11111, in_amt=0 -> DONE after 1 edge, out_data=11111; 01010 with in_amt=0 -> out_data=01010.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> out_valid and out_data stay stable, in_ready=0, a new in_valid is not accepted; raise out_ready -> IDLE next edge, then the next request is accepted.
- Deassert rst_n asynchronously mid-SHIFT (in_data=10110, in_amt=7) -> outputs return to reset values immediately without waiting for an edge, and no out_valid follows. With ARS_SEQ_ABORT_EN defined, abort in SHIFT gives the same result at the next edge.

Source files
------------

// File: rtl/ars_shift_sequencer.sv
// ars_shift_sequencer: multi-cycle arithmetic right shift built on a 0..3-place shifter
//   Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_amt request
//   handshake; out_valid/out_ready/out_data result handshake; busy = not IDLE.
//   Optional: define ARS_SEQ_ABORT_EN to add input abort (cancels SHIFT/DONE).
module ArithmeticRightShifter #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [1:0]   ctrl,
    output logic [N-1:0] y
);
    assign y = $signed(a) >>> ctrl;
endmodule

module ars_shift_sequencer #(
    parameter int N     = 5,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ARS_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [N-1:0]     out_data,
    output logic             busy
);
    localparam int RW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [N-1:0]  data;
    logic [RW-1:0] rem;
    logic [1:0]    step;
    logic [N-1:0]  sh_out;
    logic          kill;

`ifdef ARS_SEQ_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif

    // Largest pass the shifter supports is 3 places
    assign step = rem > RW'(2) ? 2'd3 : rem[1:0];

    ArithmeticRightShifter #(.N(N)) u_shifter (.a(data), .ctrl(step), .y(sh_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            rem   <= '0;
        end else if (kill) begin
            state <= IDLE;
            data  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    data <= in_data;
                    // Shifting by N-1 already leaves only sign bits, so clamp there
                    if (in_amt >= AMT_W'(N - 1)) begin
                        rem   <= RW'(N - 1);
                        state <= SHIFT;
                    end else begin
                        rem   <= RW'(in_amt);
                        state <= in_amt == '0 ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data  <= sh_out;
                    rem   <= rem - RW'(step);
                    state <= rem == RW'(step) ? DONE : SHIFT;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;
    assign out_data  = data;
endmodule

// File: tb/tb_ars_shift_sequencer.sv
// tb_ars_shift_sequencer: randomized and directed checks against a floor-division model
module tb_ars_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic [3:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       busy;
`ifdef ARS_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    int tests = 0;
    int fails = 0;

    ars_shift_sequencer #(.N(5), .AMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ARS_SEQ_ABORT_EN
        .abort(abort),
`endif
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [4:0] d, input int e);
        int v, p, q;
        v = d[4] ? int'(d) - 32 : int'(d);
        p = 1 << e;
        q = v / p;
        if (v % p != 0 && v < 0) q--;
        return q[4:0];
    endfunction

    task automatic do_op(input logic [4:0] d, input logic [3:0] a, input int hold);
        int eff, lat;
        logic [4:0] exp_d;
        eff = a >= 4 ? 4 : int'(a);
        exp_d = model(d, eff);
        check("rdy_idle", in_ready, 1);
        in_valid = 1'b1; in_data = d; in_amt = a; out_ready = hold == 0;
        @(negedge clk);
        in_valid = 1'b0; in_data = 5'($urandom); in_amt = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("rdy_busy", in_ready, 0);
            check("busy_shift", busy, 1);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 1 + (eff + 2) / 3);
        check("data", out_data, exp_d);
        check("busy_done", busy, 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp_d);
            check("hold_rdy", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("retire_valid", out_valid, 0);
        check("retire_rdy", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(5'b01010, 4'd2, 0);
        do_op(5'b10110, 4'd3, 0);
        do_op(5'b10110, 4'd1, 0);
        do_op(5'b10110, 4'd9, 0);
        do_op(5'b01010, 4'd15, 0);
        do_op(5'b11111, 4'd0, 0);
        do_op(5'b01010, 4'd0, 0);
        do_op(5'b10110, 4'd2, 4);
        do_op(5'b00111, 4'd5, 0);
        for (int i = 0; i < 60; i++)
            do_op(5'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        // asynchronous reset in the middle of a SHIFT sequence
        in_valid = 1'b1; in_data = 5'b10110; in_amt = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_rdy", in_ready, 1);
        check("arst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 0);
        end
`ifdef ARS_SEQ_ABORT_EN
        in_valid = 1'b1; in_data = 5'b10110; in_amt = 4'd7;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rdy", in_ready, 1);
        check("abort_data", out_data, 0);
        repeat (4) begin
            @(negedge clk);
            check("post_abort_valid", out_valid, 0);
        end
`endif
        do_op(5'b10000, 4'd4, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
